// File: rtl/mips_ctrl_pkg.sv
// Shared state codes and helpers for the MIPS multicycle control sequencer.
package mips_ctrl_pkg;
  localparam int STATE_W = 7;

  localparam logic [STATE_W-1:0] S_RESET      = 7'd0;
  localparam logic [STATE_W-1:0] S_FETCH_ADDR = 7'd1;
  localparam logic [STATE_W-1:0] S_FETCH_WAIT = 7'd2;
  localparam logic [STATE_W-1:0] S_FETCH_IR   = 7'd3;
  localparam logic [STATE_W-1:0] S_DECODE     = 7'd4;
  localparam logic [STATE_W-1:0] S_ADDU       = 7'd6;
  localparam logic [STATE_W-1:0] S_SW_ADDR    = 7'd7;
  localparam logic [STATE_W-1:0] S_SW_WAIT    = 7'd8;
  localparam logic [STATE_W-1:0] S_BEQ        = 7'd11;
  localparam logic [STATE_W-1:0] S_BEQ_TK     = 7'd12;
  localparam logic [STATE_W-1:0] S_LW_ADDR    = 7'd13;
  localparam logic [STATE_W-1:0] S_LW_WAIT    = 7'd14;
  localparam logic [STATE_W-1:0] S_LW_WB      = 7'd15;
  localparam logic [STATE_W-1:0] S_ALU_LO     = 7'd17;
  localparam logic [STATE_W-1:0] S_ALU_HI     = 7'd33;
  localparam logic [STATE_W-1:0] S_MOVN       = 7'd34;
  localparam logic [STATE_W-1:0] S_MOVZ       = 7'd35;
  localparam logic [STATE_W-1:0] S_BGEZ       = 7'd37;
  localparam logic [STATE_W-1:0] S_BGEZ_TK    = 7'd38;
  localparam logic [STATE_W-1:0] S_BGTZ       = 7'd39;
  localparam logic [STATE_W-1:0] S_BGTZ_TK    = 7'd40;
  localparam logic [STATE_W-1:0] S_BNE        = 7'd41;
  localparam logic [STATE_W-1:0] S_BNE_TK     = 7'd42;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // ALU-class states (single writeback cycle, then back to fetch)
  function automatic logic is_alu(input logic [STATE_W-1:0] s);
    return (s == S_ADDU) || (s >= S_ALU_LO && s <= S_MOVZ);
  endfunction

  // states that hold the memory handshake open
  function automatic logic is_wait(input logic [STATE_W-1:0] s);
    return (s == S_FETCH_WAIT) || (s == S_SW_WAIT) || (s == S_LW_WAIT);
  endfunction

  // second cycle of a branch, where PC loads only if taken
  function automatic logic is_br_tk(input logic [STATE_W-1:0] s);
    return (s == S_BEQ_TK) || (s == S_BGEZ_TK) || (s == S_BGTZ_TK) || (s == S_BNE_TK);
  endfunction
endpackage

// File: rtl/mips_ctrl_sequencer_if.sv
// Control/datapath bundle between the sequencer and the MIPS datapath.
interface mips_ctrl_sequencer_if;
  import mips_ctrl_pkg::*;
  logic [STATE_W-1:0] Dispatch_State;
  logic               MOC;
  logic               Cond;
  logic [STATE_W-1:0] State;
  logic               PC_Ld;
  logic               IR_Ld;
  logic               MAR_Ld;
  logic               MDR_Ld;
  logic               RF_Ld;
  logic               MOV;
  logic               RW;
  logic               Bus_Error;
  logic               Illegal_Instr;

  modport master (
    input  Dispatch_State, MOC, Cond,
    output State, PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW, Bus_Error, Illegal_Instr
  );
  modport slave (
    output Dispatch_State, MOC, Cond,
    input  State, PC_Ld, IR_Ld, MAR_Ld, MDR_Ld, RF_Ld, MOV, RW, Bus_Error, Illegal_Instr
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory-wait cycle counter with clear, enable and terminal-count flag.
module mem_wait_timer #(
  parameter int MOC_TIMEOUT = 255,
  parameter int TMR_W       = 10
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TMR_W-1:0] cnt;

  // count wait cycles; held at zero outside wait states so entry starts fresh
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TMR_W'(MOC_TIMEOUT - 1));
endmodule

// File: rtl/mips_ctrl_sequencer.sv
// Multicycle MIPS control sequencer: fetch, decode, dispatch, execute.
module mips_ctrl_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MOC_TIMEOUT = 255,
  parameter int TMR_W       = 10
) (
  input  logic             Clk,
  input  logic             Reset_n,
  mips_ctrl_sequencer_if.master bus
);
  logic [STATE_W-1:0] state;
  logic               be_q, ii_q;
  logic               in_wait, tmo;

  assign in_wait = is_wait(state);

  mem_wait_timer #(.MOC_TIMEOUT(MOC_TIMEOUT), .TMR_W(TMR_W)) u_tmr (
    .gclk   (Clk),
    .grst_n (Reset_n),
    .clr    (!in_wait),
    .en     (in_wait && !bus.MOC),
    .tc     (tmo)
  );

  // state register and the two one-cycle error flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_RESET;
      be_q  <= 1'b0;
      ii_q  <= 1'b0;
    end else begin
      be_q <= 1'b0;
      ii_q <= 1'b0;
      case (state)
        S_RESET:      state <= S_FETCH_ADDR;
        S_FETCH_ADDR: state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          if (bus.MOC)  state <= S_FETCH_IR;
          else if (tmo) begin state <= S_RESET; be_q <= 1'b1; end
        end
        S_FETCH_IR:   state <= S_DECODE;
        S_DECODE: begin
          if (bus.Dispatch_State == S_RESET) begin
            state <= S_FETCH_ADDR;
            ii_q  <= 1'b1;
          end else begin
            state <= bus.Dispatch_State;
          end
        end
        S_SW_ADDR:    state <= S_SW_WAIT;
        S_SW_WAIT: begin
          if (bus.MOC)  state <= S_FETCH_ADDR;
          else if (tmo) begin state <= S_RESET; be_q <= 1'b1; end
        end
        S_LW_ADDR:    state <= S_LW_WAIT;
        S_LW_WAIT: begin
          if (bus.MOC)  state <= S_LW_WB;
          else if (tmo) begin state <= S_RESET; be_q <= 1'b1; end
        end
        S_LW_WB:      state <= S_FETCH_ADDR;
        S_BEQ:        state <= S_BEQ_TK;
        S_BGEZ:       state <= S_BGEZ_TK;
        S_BGTZ:       state <= S_BGTZ_TK;
        S_BNE:        state <= S_BNE_TK;
        S_BEQ_TK, S_BGEZ_TK, S_BGTZ_TK, S_BNE_TK: state <= S_FETCH_ADDR;
        // ALU range finishes in one cycle; anything unlisted is corruption
        default:      state <= is_alu(state) ? S_FETCH_ADDR : S_RESET;
      endcase
    end
  end

  // Moore output decode; PC_Ld/RF_Ld fold in Cond only in conditional states
  always_comb begin
    bus.State         = state;
    bus.MAR_Ld        = (state == S_FETCH_ADDR) || (state == S_SW_ADDR) || (state == S_LW_ADDR);
    bus.MDR_Ld        = (state == S_FETCH_WAIT) || (state == S_LW_WAIT) || (state == S_SW_ADDR);
    bus.IR_Ld         = (state == S_FETCH_IR);
    bus.PC_Ld         = (state == S_FETCH_IR) || (is_br_tk(state) && bus.Cond);
    bus.RF_Ld         = (state == S_LW_WB)
                      || (is_alu(state) && state != S_MOVN && state != S_MOVZ)
                      || ((state == S_MOVN || state == S_MOVZ) && bus.Cond);
    bus.MOV           = in_wait;
    bus.RW            = (state == S_FETCH_WAIT || state == S_LW_WAIT) ? RW_READ : RW_WRITE;
    bus.Bus_Error     = be_q;
    bus.Illegal_Instr = ii_q;
  end
endmodule

// File: tb/tb_mips_ctrl_sequencer.sv
// Randomized instruction-stream bench for mips_ctrl_sequencer.
module tb_mips_ctrl_sequencer;
  localparam int TO = 4;

  localparam logic [8:0] F_PC  = 9'h100;
  localparam logic [8:0] F_IR  = 9'h080;
  localparam logic [8:0] F_MAR = 9'h040;
  localparam logic [8:0] F_MDR = 9'h020;
  localparam logic [8:0] F_RF  = 9'h010;
  localparam logic [8:0] F_MOV = 9'h008;
  localparam logic [8:0] F_RW  = 9'h004;
  localparam logic [8:0] F_BE  = 9'h002;
  localparam logic [8:0] F_II  = 9'h001;

  typedef struct {
    logic [6:0] st;
    logic [8:0] fl;
    logic [6:0] disp;
    logic       moc;
    logic       cond;
  } cyc_t;

  logic Clk = 1'b0;
  logic Reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  cyc_t tr[$];
  logic [8:0] pend = '0;

  mips_ctrl_sequencer_if bus();

  mips_ctrl_sequencer #(.MOC_TIMEOUT(TO), .TMR_W(10)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got state=%0d flags=%b, want state=%0d flags=%b",
               tag, obs[15:9], obs[8:0], exp[15:9], exp[8:0]);
    end
  endtask

  function automatic logic [6:0] j7();
    return 7'($urandom);
  endfunction

  function automatic logic j1();
    return 1'($urandom);
  endfunction

  // one expected cycle; pending error flags land on the next pushed cycle
  task automatic push(input logic [6:0] st, input logic [8:0] fl,
                      input logic [6:0] disp, input logic moc, input logic cond);
    cyc_t c;
    c.st = st; c.fl = fl | pend; c.disp = disp; c.moc = moc; c.cond = cond;
    pend = '0;
    tr.push_back(c);
  endtask

  // memory wait: MOC held low for d cycles, then high; TO low cycles => bus error
  task automatic mem_wait(input logic [6:0] st, input logic [8:0] fl, output bit ok);
    int d;
    bit done;
    d = $urandom_range(0, TO + 1);
    ok = 0; done = 0;
    for (int k = 0; k < TO && !done; k++) begin
      if (k >= d) begin
        push(st, fl, j7(), 1'b1, j1());
        ok = 1; done = 1;
      end else begin
        push(st, fl, j7(), 1'b0, j1());
      end
    end
    if (!ok) begin
      push(7'd0, 9'h0, j7(), j1(), j1());
      pend = F_BE;
      // the error flag belongs to the state-0 cycle just pushed
      tr[tr.size()-1].fl = tr[tr.size()-1].fl | pend;
      pend = '0;
    end
  endtask

  task automatic gen_instr();
    bit ok;
    logic c;
    int cls;
    logic [6:0] code;
    logic [6:0] bad [9] = '{7'd5, 7'd9, 7'd10, 7'd16, 7'd36, 7'd43, 7'd64, 7'd100, 7'd127};
    logic [6:0] brs [4] = '{7'd11, 7'd37, 7'd39, 7'd41};
    push(7'd1, F_MAR, j7(), j1(), j1());
    mem_wait(7'd2, F_MOV | F_RW | F_MDR, ok);
    if (ok) begin
      push(7'd3, F_IR | F_PC, j7(), j1(), j1());
      cls = $urandom_range(0, 6);
      case (cls)
        0: begin
          code = 7'($urandom_range(16, 33));
          if (code == 7'd16) code = 7'd6;
        end
        1: code = j1() ? 7'd34 : 7'd35;
        2: code = 7'd7;
        3: code = 7'd13;
        4: code = brs[$urandom_range(0, 3)];
        5: code = 7'd0;
        default: code = bad[$urandom_range(0, 8)];
      endcase
      push(7'd4, 9'h0, code, j1(), j1());
      case (cls)
        0: push(code, F_RF, j7(), j1(), j1());
        1: begin
          c = j1();
          push(code, c ? F_RF : 9'h0, j7(), j1(), c);
        end
        2: begin
          push(7'd7, F_MAR | F_MDR, j7(), j1(), j1());
          mem_wait(7'd8, F_MOV, ok);
        end
        3: begin
          push(7'd13, F_MAR, j7(), j1(), j1());
          mem_wait(7'd14, F_MOV | F_RW | F_MDR, ok);
          if (ok) push(7'd15, F_RF, j7(), j1(), j1());
        end
        4: begin
          push(code, 9'h0, j7(), j1(), j1());
          c = j1();
          push(code + 7'd1, c ? F_PC : 9'h0, j7(), j1(), c);
        end
        5: pend = F_II;
        default: begin
          push(code, 9'h0, j7(), j1(), j1());
          push(7'd0, 9'h0, j7(), j1(), j1());
        end
      endcase
    end
  endtask

  function automatic logic [15:0] obs_vec(input logic mov_exp);
    return {bus.State, bus.PC_Ld, bus.IR_Ld, bus.MAR_Ld, bus.MDR_Ld, bus.RF_Ld,
            bus.MOV, mov_exp ? bus.RW : 1'b0, bus.Bus_Error, bus.Illegal_Instr};
  endfunction

  // apply each cycle's inputs after the edge, check mid-cycle
  task automatic play();
    cyc_t c;
    while (tr.size() > 0) begin
      c = tr.pop_front();
      bus.Dispatch_State = c.disp;
      bus.MOC            = c.moc;
      bus.Cond           = c.cond;
      @(negedge Clk);
      chk($sformatf("st%0d", c.st), obs_vec(c.fl[3]), {c.st, c.fl});
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    bus.Dispatch_State = '0;
    bus.MOC = 1'b0;
    bus.Cond = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset", obs_vec(1'b1), 16'h0);
    Reset_n = 1'b1;

    push(7'd0, 9'h0, j7(), j1(), j1());
    for (int i = 0; i < 300; i++) gen_instr();
    push(7'd1, F_MAR, j7(), j1(), j1());
    play();

    // reset mid load-wait abandons the access before the next edge
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    push(7'd0, 9'h0, j7(), j1(), j1());
    push(7'd1, F_MAR, j7(), j1(), j1());
    push(7'd2, F_MOV | F_RW | F_MDR, j7(), 1'b1, j1());
    push(7'd3, F_IR | F_PC, j7(), j1(), j1());
    push(7'd4, 9'h0, 7'd13, j1(), j1());
    push(7'd13, F_MAR, j7(), j1(), j1());
    play();
    bus.MOC = 1'b0;
    #2;
    chk("lw_wait", obs_vec(1'b1), {7'd14, F_MOV | F_RW | F_MDR});
    Reset_n = 1'b0;
    #1;
    chk("async_rst", obs_vec(1'b1), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
